// File: rtl/tlc_phase_sched.sv
// Timed phase scheduler for a two-road intersection with a pedestrian walk phase.
// Optional flashing mode (FLASH input, blinking A yellow / B red) is compiled in with `define TLC_FLASH_EN.
module tlc_phase_sched #(
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic       TA,
  input  logic       TB,
  input  logic       PED_REQ,
`ifdef TLC_FLASH_EN
  input  logic       FLASH,
`endif
  output logic       ALRED,
  output logic       ALYELLOW,
  output logic       ALGREEN,
  output logic       BLRED,
  output logic       BLYELLOW,
  output logic       BLGREEN,
  output logic       WALK,
  output logic       PED_ACK,
  output logic [2:0] PHASE
);

  typedef enum logic [2:0] {
    A_GRN   = 3'd0,
    A_YEL   = 3'd1,
    AR_A    = 3'd2,
    B_GRN   = 3'd3,
    B_YEL   = 3'd4,
    AR_B    = 3'd5,
    PED     = 3'd6,
    FLASH_S = 3'd7
  } state_t;

  localparam logic ROAD_A = 1'b0;
  localparam logic ROAD_B = 1'b1;

  localparam logic [CNT_W:0]   GMIN_N = (CNT_W+1)'(GREEN_MIN);
  localparam logic [CNT_W:0]   GMAX_N = (CNT_W+1)'(GREEN_MAX);
  localparam logic [CNT_W:0]   YEL_N  = (CNT_W+1)'(YELLOW_T);
  localparam logic [CNT_W:0]   AR_N   = (CNT_W+1)'(ALLRED_T);
  localparam logic [CNT_W:0]   WALK_N = (CNT_W+1)'(WALK_T);
  localparam logic [CNT_W-1:0] GMAX_T = CNT_W'(GREEN_MAX);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W:0]   n;
  logic             ped_pend, ped_pend_nxt;
  logic             next_road, next_road_nxt;
  logic             enter_ped;
  logic             ped_ack_q;
  logic             blink;

  // n is the tick count within the current state including this cycle's tick
  assign n = {1'b0, timer} + {{CNT_W{1'b0}}, 1'b1};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= A_GRN;
      timer     <= '0;
      ped_pend  <= 1'b0;
      next_road <= ROAD_B;
      ped_ack_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ped_pend  <= ped_pend_nxt;
      next_road <= next_road_nxt;
      ped_ack_q <= enter_ped;
      if (state_nxt != state)
        timer <= '0;
      else if (TICK && (timer < GMAX_T))
        timer <= timer + 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    next_road_nxt = next_road;
    case (state)
      A_GRN:
        if (TICK && (((n >= GMIN_N) && !TA) || ((n >= GMAX_N) && (TB || ped_pend))))
          state_nxt = A_YEL;
      A_YEL:
        if (TICK && (n == YEL_N))
          state_nxt = AR_A;
      AR_A:
        if (TICK && (n == AR_N)) begin
          if (ped_pend) begin
            state_nxt     = PED;
            next_road_nxt = ROAD_B;
          end else begin
            state_nxt = B_GRN;
          end
        end
      B_GRN:
        if (TICK && (((n >= GMIN_N) && !TB) || ((n >= GMAX_N) && (TA || ped_pend))))
          state_nxt = B_YEL;
      B_YEL:
        if (TICK && (n == YEL_N))
          state_nxt = AR_B;
      AR_B:
        if (TICK && (n == AR_N)) begin
          if (ped_pend) begin
            state_nxt     = PED;
            next_road_nxt = ROAD_A;
          end else begin
            state_nxt = A_GRN;
          end
        end
      PED:
        if (TICK && (n == WALK_N))
          state_nxt = (next_road == ROAD_A) ? A_GRN : B_GRN;
`ifdef TLC_FLASH_EN
      FLASH_S:
        if (!FLASH)
          state_nxt = AR_B;
`endif
      // Unknown codes recover through the B clearance so road A is served next
      default:
        state_nxt = AR_B;
    endcase
`ifdef TLC_FLASH_EN
    if (FLASH)
      state_nxt = FLASH_S;
`endif
  end

  // A request arriving on the PED entry cycle stays latched for the next boundary
  assign enter_ped    = (state_nxt == PED) && (state != PED);
  assign ped_pend_nxt = PED_REQ | (ped_pend & ~enter_ped);

`ifdef TLC_FLASH_EN
  always_ff @(posedge CLK) begin
    if (RESET)
      blink <= 1'b0;
    else if ((state_nxt == FLASH_S) && (state != FLASH_S))
      blink <= 1'b1;
    else if ((state == FLASH_S) && TICK)
      blink <= ~blink;
  end
`else
  assign blink = 1'b0;
`endif

  always_comb begin
    ALRED    = 1'b1;
    ALYELLOW = 1'b0;
    ALGREEN  = 1'b0;
    BLRED    = 1'b1;
    BLYELLOW = 1'b0;
    BLGREEN  = 1'b0;
    WALK     = 1'b0;
    case (state)
      A_GRN: begin
        ALRED   = 1'b0;
        ALGREEN = 1'b1;
      end
      A_YEL: begin
        ALRED    = 1'b0;
        ALYELLOW = 1'b1;
      end
      B_GRN: begin
        BLRED   = 1'b0;
        BLGREEN = 1'b1;
      end
      B_YEL: begin
        BLRED    = 1'b0;
        BLYELLOW = 1'b1;
      end
      PED:
        WALK = 1'b1;
`ifdef TLC_FLASH_EN
      FLASH_S: begin
        ALRED    = 1'b0;
        ALYELLOW = blink;
        BLRED    = blink;
      end
`endif
      default: ;
    endcase
  end

  assign PED_ACK = ped_ack_q;
  assign PHASE   = state;

endmodule

// File: tb/tb_tlc_phase_sched.sv
// Self-checking bench for tlc_phase_sched: a table-driven handoff sequence plus hand-built
// multi-cycle scenarios, each step's expected outputs queued on drive and checked after the edge.
module tb_tlc_phase_sched;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       TICK = 1'b0;
  logic       TA = 1'b0;
  logic       TB = 1'b0;
  logic       PED_REQ = 1'b0;
`ifdef TLC_FLASH_EN
  logic       FLASH = 1'b0;
`endif
  logic       ALRED, ALYELLOW, ALGREEN, BLRED, BLYELLOW, BLGREEN, WALK, PED_ACK;
  logic [2:0] PHASE;

  tlc_phase_sched dut (
    .CLK(CLK),
    .RESET(RESET),
    .TICK(TICK),
    .TA(TA),
    .TB(TB),
    .PED_REQ(PED_REQ),
`ifdef TLC_FLASH_EN
    .FLASH(FLASH),
`endif
    .ALRED(ALRED),
    .ALYELLOW(ALYELLOW),
    .ALGREEN(ALGREEN),
    .BLRED(BLRED),
    .BLYELLOW(BLYELLOW),
    .BLGREEN(BLGREEN),
    .WALK(WALK),
    .PED_ACK(PED_ACK),
    .PHASE(PHASE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       tick;
    logic       ta;
    logic       tb;
    logic       ped;
    logic [2:0] phase;
    logic       ack;
  } vec_t;

  typedef struct {
    string       name;
    int          idx;
    logic [10:0] exp;
  } sb_t;

  sb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Expected {PHASE, ALR, ALY, ALG, BLR, BLY, BLG, WALK, PED_ACK} for a given state code
  function automatic logic [10:0] expectOut(input logic [2:0] ph, input logic ack);
    logic ag, ay, bg, by;
    ag = (ph == 3'd0);
    ay = (ph == 3'd1);
    bg = (ph == 3'd3);
    by = (ph == 3'd4);
    return {ph, !(ag || ay), ay, ag, !(bg || by), by, bg, (ph == 3'd6), ack};
  endfunction

  // Phase reached on tick i of a min-green handoff from A to B (A_GRN -> A_YEL -> AR_A -> B_GRN)
  function automatic logic [2:0] handoffPhase(input int i);
    if (i < 4)       return 3'd0;
    else if (i < 6)  return 3'd1;
    else if (i == 6) return 3'd2;
    else             return 3'd3;
  endfunction

  task automatic checkOutput();
    sb_t         e;
    logic [10:0] act;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: no expected entry queued");
      return;
    end
    e   = exp_q.pop_front();
    act = {PHASE, ALRED, ALYELLOW, ALGREEN, BLRED, BLYELLOW, BLGREEN, WALK, PED_ACK};
    if (act !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got phase=%0d lamps=%b walk=%b ack=%b, expected phase=%0d lamps=%b walk=%b ack=%b",
               e.name, e.idx, act[10:8], act[7:2], act[1], act[0],
               e.exp[10:8], e.exp[7:2], e.exp[1], e.exp[0]);
    end
  endtask

  task automatic applyStimulus(input string name, input int idx, input logic rst, input logic tick,
                               input logic ta, input logic tb, input logic ped,
                               input logic [2:0] ph, input logic ack);
    sb_t e;
    @(negedge CLK);
    RESET   = rst;
    TICK    = tick;
    TA      = ta;
    TB      = tb;
    PED_REQ = ped;
    e.name  = name;
    e.idx   = idx;
    e.exp   = expectOut(ph, ack);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  vec_t       tbl[11];
  logic [2:0] ph;

  initial begin
    // Min-green handoff: TA=0, TB=1 after reset
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0};

    // Hold: A green with sustained demand and nobody waiting
    applyStimulus("hold_rst", 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int i = 1; i <= 30; i++)
      applyStimulus("hold", i, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

    for (int i = 0; i < 11; i++)
      applyStimulus("handoff", i, tbl[i].rst, tbl[i].tick, tbl[i].ta, tbl[i].tb, tbl[i].ped,
                    tbl[i].phase, tbl[i].ack);

    // Max-green bound on both roads with both sensors active
    applyStimulus("maxg_rst", 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      ph = (i < 12) ? 3'd0 : (i < 14) ? 3'd1 : (i < 15) ? 3'd2 :
           (i < 27) ? 3'd3 : (i < 29) ? 3'd4 : (i < 30) ? 3'd5 : 3'd0;
      applyStimulus("maxg", i, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ph, 1'b0);
    end

    // Pedestrian: request in B green, second request on the PED entry cycle
    applyStimulus("ped_rst", 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 1; i <= 7; i++)
      applyStimulus("ped_pre", i, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, handoffPhase(i), 1'b0);
    for (int j = 1; j <= 39; j++) begin
      ph = (j < 4) ? 3'd3 : (j < 6) ? 3'd4 : (j < 7) ? 3'd5 : (j < 12) ? 3'd6 :
           (j < 24) ? 3'd0 : (j < 26) ? 3'd1 : (j < 27) ? 3'd2 : (j < 32) ? 3'd6 :
           (j < 36) ? 3'd3 : (j < 38) ? 3'd4 : (j < 39) ? 3'd5 : 3'd0;
      applyStimulus("ped", j, 1'b0, 1'b1, 1'b1, 1'b0, (j == 1) || (j == 7), ph,
                    (j == 7) || (j == 27));
    end

    // Sparse tick: one tick every 4 cycles, request latched on a non-tick cycle
    applyStimulus("sparse_rst", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int c = 1; c <= 31; c++) begin
      ph = (c < 16) ? 3'd0 : (c < 24) ? 3'd1 : (c < 28) ? 3'd2 : 3'd6;
      applyStimulus("sparse", c, 1'b0, (c % 4) == 0, 1'b0, 1'b0, c == 17, ph, c == 28);
    end

    // Reset in B yellow with a pending request must drop the request
    applyStimulus("rstmid_rst", 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 1; i <= 7; i++)
      applyStimulus("rstmid_pre", i, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, handoffPhase(i), 1'b0);
    for (int j = 1; j <= 4; j++)
      applyStimulus("rstmid_b", j, 1'b0, 1'b1, 1'b1, 1'b0, j == 1, (j < 4) ? 3'd3 : 3'd4, 1'b0);
    applyStimulus("rstmid_hit", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int k = 1; k <= 10; k++)
      applyStimulus("rstmid_post", k, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, handoffPhase(k), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlc_phase_sched.md
Name: tlc_phase_sched

Overview:
Timed phase scheduler for a two-road intersection with a pedestrian crossing. It sequences green, yellow and all-red clearance for road A and road B, using durations counted in ticks of an external timebase. Sensor inputs can extend a green phase, bounded by a maximum so the other road is not starved. A latched pedestrian request inserts a walk phase at the next all-red boundary. It sits between the sensor/button front end and the lamp drivers.

Parameters:
CNT_W, 8, phase timer width; every duration below must be >=1 and < 2**CNT_W
GREEN_MIN, 4, minimum green length in ticks
GREEN_MAX, 12, maximum green length in ticks while the other road or a pedestrian is waiting; must be >= GREEN_MIN
YELLOW_T, 2, yellow length in ticks
ALLRED_T, 1, all-red clearance length in ticks
WALK_T, 5, pedestrian walk length in ticks

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  synchronous, active-high reset
TICK  in  1  one-cycle timebase strobe; the timer and state advance only on cycles with TICK=1
TA  in  1  road A traffic sensor, level
TB  in  1  road B traffic sensor, level
PED_REQ  in  1  pedestrian button, pulse or level
ALRED, ALYELLOW, ALGREEN  out  1 each  road A lamps
BLRED, BLYELLOW, BLGREEN  out  1 each  road B lamps
WALK  out  1  pedestrian walk lamp
PED_ACK  out  1  one-cycle pulse on the cycle the walk phase begins
PHASE  out  3  current state code

Behaviour:
- Clocking and reset: one clock, CLK. RESET is synchronous and active-high. RESET has priority over every other input, including mid-phase.
- Reset state: A_GRN, timer=0, ped_pend=0, next_road=B. Outputs after reset: ALGREEN=1, BLRED=1, PED_ACK=0, all other lamps 0, PHASE=0.
- States and PHASE codes: A_GRN=0, A_YEL=1, AR_A=2, B_GRN=3, B_YEL=4, AR_B=5, PED=6, FLASH=7.
- Moore outputs, decoded from state only:
  - ALGREEN in A_GRN; ALYELLOW in A_YEL; ALRED in every other state.
  - BLGREEN in B_GRN; BLYELLOW in B_YEL; BLRED in every other state.
  - WALK in PED.
- Timer:
  - Cleared on every state change.
  - Otherwise increments on TICK and saturates at GREEN_MAX.
  - n = timer+1 on a TICK cycle, i.e. the tick count within the state including the current tick.
  - All transitions are taken only on a TICK cycle.
- Green exit, X in {A,B}, Y = the other road: X_GRN -> X_YEL when either
  - n>=GREEN_MIN and TX=0, or
  - n>=GREEN_MAX and (TY | ped_pend).
  - Otherwise the state holds. With TX=1 and no demand, green holds indefinitely and the timer saturates.
- X_YEL -> AR_X when n==YELLOW_T.
- AR_X, when n==ALLRED_T:
  - -> PED if ped_pend=1, with next_road=Y.
  - Else -> Y_GRN.
- PED -> next_road green when n==WALK_T.
- ped_pend update, every cycle: ped_pend_next = PED_REQ | (ped_pend & ~enter_PED). A request that coincides with entry into PED stays latched and is served at the next all-red boundary.
- PED_ACK: high exactly on the first cycle in PED.
- Illegal or unused state code (7 when FLASH is not compiled in): go to AR_B on the next clock, so the next green is A.
- TICK=0: state, timer and next_road hold; ped_pend still latches.

Optional Feature:
Macro TLC_FLASH_EN.
- Defined:
  - Adds input FLASH (1 bit).
  - FLASH=1 on any cycle sends the block to FLASH on the next clock, from any state.
  - In FLASH, ALYELLOW and BLRED blink: a toggle flop flips on each TICK and starts lit on entry. All other lamps are 0 and WALK=0.
  - FLASH=0 while in FLASH -> AR_B (timer 0), then normal sequencing resumes with A green next.
  - ped_pend holds through FLASH.
- Undefined: no FLASH port; code 7 is unreachable and is handled as illegal.

Test Plan:
All scenarios use default parameters and TICK=1 every cycle unless stated.
- Hold: RESET, then TA=1, TB=0, 30 cycles -> PHASE stays 0, ALGREEN=1, BLRED=1 throughout.
- Min-green handoff: after reset, TA=0, TB=1 -> PHASE 0->1 after tick 4, 1->2 after tick 6, 2->3 after tick 7; BLGREEN=1 from then on.
- Max-green bound: TA=1, TB=1 -> A_YEL entered after tick 12; B_GRN then holds up to 12 ticks before returning.
- Pedestrian: single-cycle PED_REQ during B_GRN, with TB=0 and TA=1 -> B_YEL, AR_B, then PED. PED_ACK is high for 1 cycle and WALK=1 for 5 ticks, then PHASE=0. A second PED_REQ in the PED entry cycle causes a walk after the next AR_A.
- Sparse tick: TICK every 4th cycle, TA=0 -> A_GRN lasts 16 cycles; a PED_REQ with TICK=0 is still latched.
- Reset mid-phase: assert RESET for 1 cycle while in B_YEL with ped_pend=1 -> next cycle PHASE=0, ALGREEN=1, ped_pend cleared, and no walk follows.
